// File: rtl/pool1_win_pkg.sv
// Shared constants, state encoding and window pixel indexing for the
// pooling-layer-1 window buffer.
package pool1_win_pkg;

    localparam int DW    = 16;
    localparam int W     = 14;
    localparam int K     = 5;
    localparam int OUT_N = W - K + 1;

    typedef enum logic {
        FILL = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Flat pixel position of window element (r, c), row-major, r=0 oldest.
    function automatic int pix_idx(input int r, input int c);
        return r * K + c;
    endfunction

endpackage

// File: rtl/pool1_row_ring.sv
// K-slot ring of full input rows, read back oldest-first starting at rd_base.
// A write in the same cycle is forwarded so the newest row is visible at once.
module pool1_row_ring #(
    parameter int DW = 16,
    parameter int W  = 14,
    parameter int K  = 5,
    parameter int SW = $clog2(K)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [SW-1:0]     wr_slot,
    input  logic [W*DW-1:0]   wr_row,
    input  logic [SW-1:0]     rd_base,
    output logic [K*W*DW-1:0] rd_rows
);

    logic [W*DW-1:0] mem_q [K];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_slot] <= wr_row;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_age
            logic [SW:0]     slot_sum;
            logic [SW-1:0]   slot;
            logic [W*DW-1:0] row_sel;

            always_comb begin
                slot_sum = {1'b0, rd_base} + (SW+1)'(gi);
                slot     = (slot_sum >= (SW+1)'(K)) ? SW'(slot_sum - (SW+1)'(K))
                                                     : slot_sum[SW-1:0];
                if (wr_en && (slot == wr_slot)) begin
                    row_sel = wr_row;
                end else begin
                    row_sel = mem_q[slot];
                end
            end

            assign rd_rows[gi*W*DW +: W*DW] = row_sel;
        end
    endgenerate

endmodule

// File: rtl/pool1_win_buf.sv
// Holds the last K pooled rows and emits every KxK valid-padding window, stride 1.
// Optional POOL1_WIN_DROP_CHK_EN adds drop_err/drop_cnt for rows offered while busy.
module pool1_win_buf #(
    parameter int DW = pool1_win_pkg::DW,
    parameter int W  = pool1_win_pkg::W,
    parameter int K  = pool1_win_pkg::K
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W*DW-1:0]   in_row,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [K*K*DW-1:0] out_win,
    output logic [3:0]        out_row,
    output logic [3:0]        out_col,
    output logic              frame_done
`ifdef POOL1_WIN_DROP_CHK_EN
    ,
    output logic              drop_err,
    output logic [7:0]        drop_cnt
`endif
);
    import pool1_win_pkg::*;

    localparam int SW   = $clog2(K);
    localparam int RCW  = $clog2(W + 1);
    localparam int WINW = K * K * DW;
    localparam logic [RCW-1:0] K_R      = RCW'(K);
    localparam logic [RCW-1:0] W_R      = RCW'(W);
    localparam logic [3:0]     LAST_COL = 4'(W - K);
    localparam logic [SW-1:0]  SLOT_MAX = SW'(K - 1);

    state_t            state_q, state_d;
    logic [RCW-1:0]    row_cnt_q, row_cnt_d, row_inc;
    logic [SW-1:0]     slot_q, slot_d, slot_inc, rd_base;
    logic [3:0]        col_q, col_d;
    logic [3:0]        out_row_q, out_row_d;
    logic [WINW-1:0]   out_win_q, out_win_d;
    logic              frame_done_q, frame_done_d;
    logic              wr_en, load_win;
    logic [K*W*DW-1:0] rd_rows;

    // slot_q tracks row_cnt mod K: next write slot in FILL, oldest row in SCAN.
    assign row_inc  = row_cnt_q + 1'b1;
    assign slot_inc = (slot_q == SLOT_MAX) ? '0 : slot_q + 1'b1;
    assign rd_base  = (state_q == FILL) ? slot_inc : slot_q;

    pool1_row_ring #(
        .DW(DW),
        .W (W),
        .K (K),
        .SW(SW)
    ) u_ring (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_slot(slot_q),
        .wr_row (in_row),
        .rd_base(rd_base),
        .rd_rows(rd_rows)
    );

    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        slot_d       = slot_q;
        col_d        = col_q;
        out_row_d    = out_row_q;
        out_win_d    = out_win_q;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;
        load_win     = 1'b0;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    wr_en     = 1'b1;
                    row_cnt_d = row_inc;
                    slot_d    = slot_inc;
                    if (row_inc >= K_R) begin
                        state_d   = SCAN;
                        col_d     = '0;
                        load_win  = 1'b1;
                        out_row_d = 4'(row_inc - K_R);
                    end
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (col_q < LAST_COL) begin
                        col_d    = col_q + 1'b1;
                        load_win = 1'b1;
                    end else begin
                        state_d = FILL;
                        if (row_cnt_q == W_R) begin
                            row_cnt_d    = '0;
                            slot_d       = '0;
                            frame_done_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase

        if (load_win) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    out_win_d[pix_idx(r, c)*DW +: DW] =
                        rd_rows[(r*W + int'(col_d) + c)*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            row_cnt_q    <= '0;
            slot_q       <= '0;
            col_q        <= '0;
            out_row_q    <= '0;
            out_win_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            slot_q       <= slot_d;
            col_q        <= col_d;
            out_row_q    <= out_row_d;
            out_win_q    <= out_win_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = (state_q == FILL);
    assign out_valid  = (state_q == SCAN);
    assign out_win    = out_win_q;
    assign out_row    = out_row_q;
    assign out_col    = col_q;
    assign frame_done = frame_done_q;

`ifdef POOL1_WIN_DROP_CHK_EN
    logic       drop_err_q, drop_err_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       drop_hit;

    assign drop_hit = in_valid && !in_ready;

    always_comb begin
        drop_err_d = drop_err_q | drop_hit;
        drop_cnt_d = drop_cnt_q;
        if (drop_hit && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_err_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            drop_err_q <= drop_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_err = drop_err_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pool1_win_buf.sv
// Bench for pool1_win_buf: a row-list model predicts every window, handshake
// and frame_done; directed frames cover ramp, backpressure, wrap, reset, drops.
module tb_pool1_win_buf;

    localparam int DW   = 16;
    localparam int W    = 14;
    localparam int K    = 5;
    localparam int WINW = K * K * DW;
    localparam int ROWW = W * DW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b1;
    logic [ROWW-1:0] in_row = '0;
    logic            in_ready, out_valid, frame_done;
    logic [WINW-1:0] out_win;
    logic [3:0]      out_row, out_col;
`ifdef POOL1_WIN_DROP_CHK_EN
    logic            drop_err;
    logic [7:0]      drop_cnt;
`endif

    int n_pass = 0;
    int n_total = 0;
    int win_count = 0;
    int fd_count = 0;

    always #5 clk = ~clk;

    pool1_win_buf dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_win   (out_win),
        .out_row   (out_row),
        .out_col   (out_col),
        .frame_done(frame_done)
`ifdef POOL1_WIN_DROP_CHK_EN
        ,
        .drop_err  (drop_err),
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic chk(input string name, input logic [WINW-1:0] act, input logic [WINW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic tmo(input string name);
        n_total++;
        $display("FAIL %s: got timeout required event", name);
    endtask

    function automatic logic [ROWW-1:0] mk_row(input int base, input int r);
        logic [ROWW-1:0] row;
        for (int c = 0; c < W; c++) row[c*DW +: DW] = 16'(base + r*16 + c);
        return row;
    endfunction

    function automatic logic [15:0] pix(input int r, input int c);
        return out_win[(r*K + c)*DW +: DW];
    endfunction

    // ---------------- model and per-cycle compare ----------------
    typedef struct {
        logic [WINW-1:0] win;
        logic [3:0]      r;
        logic [3:0]      c;
        bit              last;
    } exp_t;

    exp_t            exp_q[$];
    logic [ROWW-1:0] rows_m[$];
    exp_t            e_new, e_pop;
    logic [ROWW-1:0] tmp_row;
    logic [WINW-1:0] hold_win;
    logic [3:0]      hold_row, hold_col;
    bit              hold_v = 0;
    bit              fd_exp = 0;
    bit              busy;
    int              top;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                rows_m.delete();
                hold_v = 0;
                fd_exp = 0;
                continue;
            end
            busy = (exp_q.size() != 0);
            chk("in_ready", WINW'(in_ready), WINW'(!busy));
            chk("out_valid", WINW'(out_valid), WINW'(busy));
            chk("frame_done", WINW'(frame_done), WINW'(fd_exp));
            if (frame_done) fd_count++;
            if (hold_v && out_valid) begin
                chk("hold_win", out_win, hold_win);
                chk("hold_row", WINW'(out_row), WINW'(hold_row));
                chk("hold_col", WINW'(out_col), WINW'(hold_col));
            end
            hold_v = 0;
            fd_exp = 0;
            if (busy) begin
                if (out_ready) begin
                    e_pop = exp_q.pop_front();
                    chk("win", out_win, e_pop.win);
                    chk("win_row", WINW'(out_row), WINW'(e_pop.r));
                    chk("win_col", WINW'(out_col), WINW'(e_pop.c));
                    win_count++;
                    fd_exp = e_pop.last;
                end else begin
                    hold_v   = 1;
                    hold_win = out_win;
                    hold_row = out_row;
                    hold_col = out_col;
                end
            end else if (in_valid) begin
                rows_m.push_back(in_row);
                $display("row accepted: frame row %0d pixel0 %h", rows_m.size() - 1, in_row[DW-1:0]);
                if (rows_m.size() >= K) begin
                    top = rows_m.size() - K;
                    for (int c0 = 0; c0 <= W - K; c0++) begin
                        for (int r = 0; r < K; r++) begin
                            tmp_row = rows_m[top + r];
                            for (int c = 0; c < K; c++)
                                e_new.win[(r*K + c)*DW +: DW] = tmp_row[(c0 + c)*DW +: DW];
                        end
                        e_new.r    = 4'(top);
                        e_new.c    = 4'(c0);
                        e_new.last = (rows_m.size() == W) && (c0 == W - K);
                        exp_q.push_back(e_new);
                    end
                    if (rows_m.size() == W) rows_m.delete();
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_row(input logic [ROWW-1:0] row, input bit eager);
        int n = 0;
        in_row = row;
        if (eager) in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) tmo("send_row");
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (!(in_ready && !out_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) tmo("drain");
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_win(input int r, input int c, output bit ok);
        int n = 0;
        ok = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (out_valid && out_row == 4'(r) && out_col == 4'(c)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) tmo("wait_win");
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_in_ready"}, WINW'(in_ready), WINW'(1'b1));
        chk({tag, "_out_valid"}, WINW'(out_valid), WINW'(1'b0));
        chk({tag, "_out_win"}, out_win, '0);
        chk({tag, "_out_row"}, WINW'(out_row), WINW'(4'd0));
        chk({tag, "_out_col"}, WINW'(out_col), WINW'(4'd0));
        chk({tag, "_frame_done"}, WINW'(frame_done), WINW'(1'b0));
`ifdef POOL1_WIN_DROP_CHK_EN
        chk({tag, "_drop_err"}, WINW'(drop_err), WINW'(1'b0));
        chk({tag, "_drop_cnt"}, WINW'(drop_cnt), WINW'(8'd0));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    bit ok_a, ok_b;
    int w0, f0, nb, ns;

    initial begin
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset_checks("rst0");
        rst = 1'b0;
        @(posedge clk); #1;

        // Ramp frame, continuous out_ready, including the ring-wrap window.
        w0 = win_count; f0 = fd_count;
        fork
            begin
                for (int r = 0; r < W; r++) send_row(mk_row(0, r), 0);
            end
            begin
                wait_win(0, 0, ok_a);
                if (ok_a) begin
                    chk("ramp_w00_p00", WINW'(pix(0, 0)), WINW'(16'h0000));
                    chk("ramp_w00_p44", WINW'(pix(4, 4)), WINW'(16'h0044));
                end
                wait_win(3, 0, ok_a);
                if (ok_a) begin
                    chk("wrap_w30_p00", WINW'(pix(0, 0)), WINW'(16'h0030));
                    chk("wrap_w30_p40", WINW'(pix(4, 0)), WINW'(16'h0070));
                end
                wait_win(9, 9, ok_a);
                if (ok_a) begin
                    chk("ramp_w99_p00", WINW'(pix(0, 0)), WINW'(16'h0099));
                    chk("ramp_w99_p44", WINW'(pix(4, 4)), WINW'(16'h00DD));
                end
            end
        join
        drain();
        chk("ramp_windows", WINW'(win_count - w0), WINW'(100));
        chk("ramp_frame_done", WINW'(fd_count - f0), WINW'(1));

        // Backpressure 1,0,0,1 during the first scan.
        w0 = win_count; f0 = fd_count;
        fork
            begin
                for (int r = 0; r < W; r++) send_row(mk_row('h1000, r), 0);
            end
            begin
                nb = 0;
                while (!out_valid && nb < 500) begin
                    @(posedge clk); #1;
                    nb++;
                end
                if (!out_valid) tmo("bp_wait");
                @(posedge clk); #1;
                out_ready = 1'b0;
                chk("bp_col_held_a", WINW'(out_col), WINW'(4'd1));
                @(posedge clk); #1;
                chk("bp_col_held_b", WINW'(out_col), WINW'(4'd1));
                chk("bp_p00_held", WINW'(pix(0, 0)), WINW'(16'h1001));
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_windows", WINW'(win_count - w0), WINW'(100));
        chk("bp_frame_done", WINW'(fd_count - f0), WINW'(1));

        // Two frames back to back.
        w0 = win_count; f0 = fd_count;
        fork
            begin
                for (int r = 0; r < 2 * W; r++)
                    send_row(mk_row((r < W) ? 'h2000 : 'h3000, r % W), 0);
            end
            begin
                wait_win(0, 0, ok_b);
                if (ok_b) chk("b2b_f0_p00", WINW'(pix(0, 0)), WINW'(16'h2000));
                wait_win(0, 0, ok_b);
                if (ok_b) begin
                    chk("b2b_f1_p00", WINW'(pix(0, 0)), WINW'(16'h3000));
                    chk("b2b_f1_p44", WINW'(pix(4, 4)), WINW'(16'h3044));
                end
            end
        join
        drain();
        chk("b2b_windows", WINW'(win_count - w0), WINW'(200));
        chk("b2b_frame_done", WINW'(fd_count - f0), WINW'(2));

        // Row offered through a whole scan, then accepted.
        for (int r = 0; r < K; r++) send_row(mk_row('h5000, r), 0);
`ifdef POOL1_WIN_DROP_CHK_EN
        chk("drop_cnt_before", WINW'(drop_cnt), WINW'(8'd0));
`endif
        send_row(mk_row('h5000, 5), 1);
`ifdef POOL1_WIN_DROP_CHK_EN
        chk("drop_err_set", WINW'(drop_err), WINW'(1'b1));
        chk("drop_cnt_10", WINW'(drop_cnt), WINW'(8'd10));
`endif
        send_row(mk_row('h5000, 6), 0);
        send_row(mk_row('h5000, 7), 0);

        // Asynchronous reset at window (3,5).
        ns = 0;
        while (out_col != 4'd5 && ns < 50) begin
            @(posedge clk); #1;
            ns++;
        end
        chk("pre_rst_row", WINW'(out_row), WINW'(4'd3));
        chk("pre_rst_col", WINW'(out_col), WINW'(4'd5));
        #2 rst = 1'b1;
        #1 reset_checks("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;

        w0 = win_count; f0 = fd_count;
        fork
            begin
                for (int r = 0; r < W; r++) send_row(mk_row('h4000, r), 0);
            end
            begin
                wait_win(0, 0, ok_a);
                if (ok_a) begin
                    chk("post_rst_p00", WINW'(pix(0, 0)), WINW'(16'h4000));
                    chk("post_rst_p44", WINW'(pix(4, 4)), WINW'(16'h4044));
                end
            end
        join
        drain();
        chk("post_rst_windows", WINW'(win_count - w0), WINW'(100));
        chk("post_rst_frame_done", WINW'(fd_count - f0), WINW'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
